// File: rtl/network_sink_if.sv
// Handshake bundle between the network output stage, the sink and its consumer.
// The network side carries spike timesteps; the snk side carries packed words.
interface network_sink_if #(
    parameter int NET_NUM_OUT   = 4,
    parameter int SNK_RUN_WIDTH = 8
);
    localparam int SNK_PAY_WIDTH =
        (NET_NUM_OUT > SNK_RUN_WIDTH) ? NET_NUM_OUT : SNK_RUN_WIDTH;
    localparam int SNK_WIDTH = SNK_PAY_WIDTH + 2;

    logic                   net_valid;
    logic                   net_ready;
    logic                   net_last;
    logic [NET_NUM_OUT-1:0] net_out;
    logic                   snk_valid;
    logic                   snk_ready;
    logic [SNK_WIDTH-1:0]   snk;

    modport master (
        output net_valid, net_last, net_out, snk_ready,
        input  net_ready, snk_valid, snk
    );

    modport slave (
        input  net_valid, net_last, net_out, snk_ready,
        output net_ready, snk_valid, snk
    );
endinterface

// File: rtl/network_sink.sv
// Spike sink: run-length encodes idle timesteps and queues packed words.
// Up to two words are produced per accepted beat into a small circular FIFO.
module network_sink #(
    parameter int NET_NUM_OUT    = 4,
    parameter int SNK_RUN_WIDTH  = 8,
    parameter int SNK_FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           arstn,
    network_sink_if.slave  bus
);
    localparam int SNK_PAY_WIDTH =
        (NET_NUM_OUT > SNK_RUN_WIDTH) ? NET_NUM_OUT : SNK_RUN_WIDTH;
    localparam int SNK_WIDTH = SNK_PAY_WIDTH + 2;
    localparam int PTR_W = $clog2(SNK_FIFO_DEPTH);
    localparam int CNT_W = $clog2(SNK_FIFO_DEPTH + 1);

    localparam logic [SNK_RUN_WIDTH-1:0] RUN_MAX = '1;
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(SNK_FIFO_DEPTH - 2);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(SNK_FIFO_DEPTH - 1);

    logic [SNK_WIDTH-1:0]     mem [SNK_FIFO_DEPTH];
    logic [PTR_W-1:0]         rptr;
    logic [PTR_W-1:0]         wptr;
    logic [CNT_W-1:0]         count;
    logic [SNK_RUN_WIDTH-1:0] run_cnt;
    logic [SNK_RUN_WIDTH-1:0] run_cnt_n;
    logic [SNK_RUN_WIDTH-1:0] run_inc;
    logic                     run_en;
    logic                     accept;
    logic                     beat_zero;
    logic                     pop;
    logic [1:0]               npush;
    logic [SNK_WIDTH-1:0]     w0;
    logic [SNK_WIDTH-1:0]     w1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) return '0;
        return p + PTR_W'(1);
    endfunction

    function automatic logic [SNK_WIDTH-1:0] run_word(
        input logic                     last,
        input logic [SNK_RUN_WIDTH-1:0] n
    );
        return {last, 1'b1, SNK_PAY_WIDTH'(n)};
    endfunction

    function automatic logic [SNK_WIDTH-1:0] spk_word(
        input logic                   last,
        input logic [NET_NUM_OUT-1:0] s
    );
        return {last, 1'b0, SNK_PAY_WIDTH'(s)};
    endfunction

    // Ready depends only on registered state: room for a worst-case double push.
    assign bus.net_ready = run_en && (count <= READY_MAX);
    assign bus.snk_valid = (count != '0);
    assign bus.snk       = mem[rptr];

    assign accept    = bus.net_valid && bus.net_ready;
    assign beat_zero = (bus.net_out == '0);
    assign pop       = bus.snk_valid && bus.snk_ready;
    assign run_inc   = run_cnt + SNK_RUN_WIDTH'(1);

    // Decide which words an accepted beat emits and the next run count.
    always_comb begin
        run_cnt_n = run_cnt;
        npush     = 2'd0;
        w0        = '0;
        w1        = '0;
        unique case (1'b1)
            accept && beat_zero && !bus.net_last: begin
                if (run_inc == RUN_MAX) begin
                    npush     = 2'd1;
                    w0        = run_word(1'b0, RUN_MAX);
                    run_cnt_n = '0;
                end else begin
                    run_cnt_n = run_inc;
                end
            end
            accept && beat_zero && bus.net_last: begin
                npush     = 2'd1;
                w0        = run_word(1'b1, run_inc);
                run_cnt_n = '0;
            end
            accept && !beat_zero: begin
                run_cnt_n = '0;
                if (run_cnt != '0) begin
                    npush = 2'd2;
                    w0    = run_word(1'b0, run_cnt);
                    w1    = spk_word(bus.net_last, bus.net_out);
                end else begin
                    npush = 2'd1;
                    w0    = spk_word(bus.net_last, bus.net_out);
                end
            end
            default: ;
        endcase
    end

    // Run counter and the one-edge delay before accepting after reset.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            run_cnt <= '0;
            run_en  <= 1'b0;
        end else begin
            run_cnt <= run_cnt_n;
            run_en  <= 1'b1;
        end
    end

    // Circular FIFO: up to two writes and one read per cycle.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            for (int i = 0; i < SNK_FIFO_DEPTH; i++) mem[i] <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (npush != 2'd0) mem[wptr] <= w0;
            if (npush == 2'd2) mem[ptr_inc(wptr)] <= w1;
            if (npush == 2'd1) wptr <= ptr_inc(wptr);
            if (npush == 2'd2) wptr <= ptr_inc(ptr_inc(wptr));
            if (pop) rptr <= ptr_inc(rptr);
            count <= count + CNT_W'(npush) - CNT_W'(pop);
        end
    end
endmodule
